branch_resolve_ctrl: RTL and testbench

//   Execute-stage branch resolution controller that sequences the BranchComp comparator.
//   It drives BrUn from the branch funct3 and combines BrEq/BrLT into a taken decision.
//   It checks that decision against fetch's prediction and issues a redirect/flush handshake to the front end.
//   It keeps saturating branch and mispredict counters for CSR readout.

---
 rtl/branch_pkg.sv | 20 ++
 rtl/br_cond_eval.sv | 32 +++
 rtl/branch_resolve_ctrl.sv | 122 ++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the execute-stage branch resolution logic:
// branch funct3 encodings and the resolve/redirect/flush state encoding.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_RSV2 = 3'b010;
  localparam logic [2:0] F3_RSV3 = 3'b011;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    BR_IDLE     = 2'd0,
    BR_REDIRECT = 2'd1,
    BR_FLUSH    = 2'd2
  } brState_e;

endpackage

// File: rtl/br_cond_eval.sv
// Combinational branch condition evaluator: turns funct3 plus the BranchComp
// flags into a taken decision, flagging the two reserved branch encodings.
module br_cond_eval
  import branch_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       brEq,
  input  logic       brLt,
  input  logic       isJump,
  output logic       taken,
  output logic       illegal
);

  // Signed/unsigned selection already happened in BranchComp via BrUn, so
  // BLT/BLTU and BGE/BGEU share the same flag here.
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    if (isJump) begin
      taken = 1'b1;
    end else begin
      case (funct3)
        F3_BEQ:           taken = brEq;
        F3_BNE:           taken = !brEq;
        F3_BLT, F3_BLTU:  taken = brLt;
        F3_BGE, F3_BGEU:  taken = !brLt;
        default:          illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Execute-stage branch resolution: checks the taken decision against fetch's
// prediction, drives the redirect/flush handshake and keeps branch statistics.
module branch_resolve_ctrl
  import branch_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_is_jump,
  input  logic [2:0]       ex_funct3,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             ex_pred_taken,
  input  logic             BrEq,
  input  logic             BrLT,
  output logic             BrUn,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  input  logic             redirect_ready,
  output logic             flush_if_id,
  output logic             ex_kill,
  output logic             illegal_br,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispred_count
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYCLES - 1);

  brState_e        state;
  logic [CW-1:0]   flushCnt;
  logic            taken;
  logic            condIllegal;
  logic            resolve;
  logic            mispredict;
  logic [XLEN-1:0] correctPc;

  assign BrUn = ex_funct3[1];

  br_cond_eval uCondEval (
    .funct3  (ex_funct3),
    .brEq    (BrEq),
    .brLt    (BrLT),
    .isJump  (ex_is_jump),
    .taken   (taken),
    .illegal (condIllegal)
  );

  // Anything arriving outside IDLE is wrong-path and must leave no trace.
  assign resolve    = (state == BR_IDLE) && ex_valid && (ex_is_branch || ex_is_jump);
  assign mispredict = resolve && (taken != ex_pred_taken);
  assign correctPc  = taken ? ex_target : ex_pc + XLEN'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count  <= '0;
      mispred_count <= '0;
      illegal_br    <= 1'b0;
    end else begin
      illegal_br <= resolve && condIllegal;
      if (resolve && (branch_count != '1)) begin
        branch_count <= branch_count + CNT_W'(1);
      end
      if (mispredict && (mispred_count != '1)) begin
        mispred_count <= mispred_count + CNT_W'(1);
      end
    end
  end

  // flush_if_id and ex_kill span both REDIRECT and FLUSH; redirect_pc is only
  // loaded from IDLE so it stays put for the whole handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= BR_IDLE;
      flushCnt       <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush_if_id    <= 1'b0;
      ex_kill        <= 1'b0;
    end else begin
      case (state)
        BR_IDLE: begin
          if (mispredict) begin
            redirect_pc    <= correctPc;
            redirect_valid <= 1'b1;
            flush_if_id    <= 1'b1;
            ex_kill        <= 1'b1;
            state          <= BR_REDIRECT;
          end
        end
        BR_REDIRECT: begin
          if (redirect_ready) begin
            redirect_valid <= 1'b0;
            flushCnt       <= FLUSH_LOAD;
            state          <= BR_FLUSH;
          end
        end
        BR_FLUSH: begin
          if (flushCnt == '0) begin
            flush_if_id <= 1'b0;
            ex_kill     <= 1'b0;
            state       <= BR_IDLE;
          end else begin
            flushCnt <= flushCnt - CW'(1);
          end
        end
        default: begin
          redirect_valid <= 1'b0;
          flush_if_id    <= 1'b0;
          ex_kill        <= 1'b0;
          state          <= BR_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl with an inline BranchComp model and
// a queue of expected redirect targets.
module tb_branch_resolve_ctrl;

  localparam int XLEN         = 32;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ex_valid;
  logic             ex_is_branch;
  logic             ex_is_jump;
  logic [2:0]       ex_funct3;
  logic [XLEN-1:0]  ex_pc;
  logic [XLEN-1:0]  ex_target;
  logic             ex_pred_taken;
  logic             BrEq;
  logic             BrLT;
  logic             BrUn;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             redirect_ready;
  logic             flush_if_id;
  logic             ex_kill;
  logic             illegal_br;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispred_count;
  logic [XLEN-1:0]  opA;
  logic [XLEN-1:0]  opB;

  always #5 clk = ~clk;

  // BranchComp stand-in
  assign BrEq = (opA == opB);
  assign BrLT = BrUn ? (opA < opB) : ($signed(opA) < $signed(opB));

  branch_resolve_ctrl #(
    .XLEN(XLEN), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
    .ex_is_jump(ex_is_jump), .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .BrEq(BrEq), .BrLT(BrLT), .BrUn(BrUn),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_ready(redirect_ready),
    .flush_if_id(flush_if_id), .ex_kill(ex_kill), .illegal_br(illegal_br),
    .branch_count(branch_count), .mispred_count(mispred_count)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [XLEN-1:0]  expQ[$];
  logic [XLEN-1:0]  lastPc = '0;
  logic [CNT_W-1:0] modelBranch = '0;
  logic [CNT_W-1:0] modelMispred = '0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic bit modelTaken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return !($signed(a) < $signed(b));
      3'b110:  return a < b;
      3'b111:  return !(a < b);
      default: return 1'b0;
    endcase
  endfunction

  // Presents one instruction in the IDLE state and checks the cycle-N+1 response.
  task automatic applyStimulus(input bit isBr, input bit isJump, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] pc, input logic [31:0] tgt, input bit pred);
    bit tk, ill, mis;
    logic [XLEN-1:0] cpc;
    @(negedge clk);
    opA = a; opB = b;
    ex_is_branch = isBr; ex_is_jump = isJump; ex_funct3 = f3;
    ex_pc = pc; ex_target = tgt; ex_pred_taken = pred; ex_valid = 1'b1;
    #1;
    checkOutput("BrUn", BrUn, f3[1]);
    tk  = isJump ? 1'b1 : modelTaken(f3, a, b);
    ill = !isJump && (f3 == 3'b010 || f3 == 3'b011);
    mis = (tk != pred);
    cpc = tk ? tgt : pc + 32'd4;
    modelBranch++;
    if (mis) begin
      modelMispred++;
      expQ.push_back(cpc);
    end
    @(posedge clk); #1;
    ex_valid = 1'b0;
    checkOutput("redirect_valid", redirect_valid, mis);
    checkOutput("ex_kill", ex_kill, mis);
    checkOutput("illegal_br", illegal_br, ill);
    checkOutput("branch_count", branch_count, modelBranch);
    checkOutput("mispred_count", mispred_count, modelMispred);
    if (mis) begin
      lastPc = expQ.pop_front();
      checkOutput("redirect_pc", redirect_pc, lastPc);
    end
  endtask

  // Holds off fetch for a while, accepts the redirect and walks the flush window.
  task automatic acceptRedirect(input int hold, input bit inject);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checkOutput("hold_redirect_valid", redirect_valid, 1'b1);
      checkOutput("hold_redirect_pc", redirect_pc, lastPc);
      checkOutput("hold_flush", flush_if_id, 1'b1);
    end
    redirect_ready = 1'b1;
    @(posedge clk); #1;
    redirect_ready = 1'b0;
    checkOutput("accept_redirect_valid", redirect_valid, 1'b0);
    checkOutput("accept_flush", flush_if_id, 1'b1);
    checkOutput("accept_kill", ex_kill, 1'b1);
    for (int i = 0; i < FLUSH_CYCLES - 1; i++) begin
      if (inject && i == 0) begin
        ex_is_branch = 1'b1; ex_is_jump = 1'b0; ex_funct3 = 3'b010;
        ex_pc = 32'h900; ex_target = 32'h990; ex_pred_taken = 1'b1; ex_valid = 1'b1;
      end
      @(posedge clk); #1;
      ex_valid = 1'b0;
      checkOutput("flush_window", flush_if_id, 1'b1);
      checkOutput("flush_illegal", illegal_br, 1'b0);
      checkOutput("flush_redirect_valid", redirect_valid, 1'b0);
    end
    @(posedge clk); #1;
    checkOutput("flush_end", flush_if_id, 1'b0);
    checkOutput("kill_end", ex_kill, 1'b0);
    checkOutput("end_illegal", illegal_br, 1'b0);
    checkOutput("end_redirect_valid", redirect_valid, 1'b0);
    checkOutput("end_branch_count", branch_count, modelBranch);
    checkOutput("end_mispred_count", mispred_count, modelMispred);
  endtask

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jump = 1'b0;
    ex_funct3 = 3'b000; ex_pc = '0; ex_target = '0; ex_pred_taken = 1'b0;
    redirect_ready = 1'b0; opA = '0; opB = '0;
    #1;
    checkOutput("rst_redirect_valid", redirect_valid, 1'b0);
    checkOutput("rst_redirect_pc", redirect_pc, 32'h0);
    checkOutput("rst_flush", flush_if_id, 1'b0);
    checkOutput("rst_kill", ex_kill, 1'b0);
    checkOutput("rst_illegal", illegal_br, 1'b0);
    checkOutput("rst_branch_count", branch_count, 32'h0);
    checkOutput("rst_mispred_count", mispred_count, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // BEQ taken, predicted not-taken
    applyStimulus(1'b1, 1'b0, 3'b000, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h80, 32'h100, 1'b0);
    acceptRedirect(0, 1'b0);

    // Unsigned compares, both predicted correctly
    applyStimulus(1'b1, 1'b0, 3'b110, 32'h1, 32'h10, 32'h180, 32'h1C0, 1'b1);
    applyStimulus(1'b1, 1'b0, 3'b111, 32'hFFFFFFF0, 32'h10, 32'h184, 32'h1E0, 1'b1);

    // Signed BLT mispredict, fetch stalls the redirect for three cycles
    applyStimulus(1'b1, 1'b0, 3'b100, 32'h80000000, 32'h7FFFFFFF, 32'h200, 32'h300, 1'b0);
    acceptRedirect(3, 1'b0);

    // BGE at the top of the address space, including the pc+4 wrap
    applyStimulus(1'b1, 1'b0, 3'b101, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFC, 32'h400, 1'b1);
    applyStimulus(1'b1, 1'b0, 3'b101, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFC, 32'h400, 1'b0);
    acceptRedirect(0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b101, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFC, 32'h400, 1'b1);
    acceptRedirect(1, 1'b0);

    // Jump is taken whatever funct3 says and is never illegal
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h0, 32'h1, 32'h600, 32'h640, 1'b0);
    acceptRedirect(0, 1'b0);

    // Reserved funct3, plus a wrong-path branch during the flush
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h3, 32'h3, 32'h500, 32'h580, 1'b1);
    acceptRedirect(0, 1'b1);

    // Asynchronous reset while a redirect is outstanding
    applyStimulus(1'b1, 1'b0, 3'b000, 32'h1, 32'h2, 32'h700, 32'h780, 1'b1);
    #2; rst_n = 1'b0; #1;
    modelBranch = '0; modelMispred = '0; expQ.delete();
    checkOutput("arst_redirect_valid", redirect_valid, 1'b0);
    checkOutput("arst_redirect_pc", redirect_pc, 32'h0);
    checkOutput("arst_flush", flush_if_id, 1'b0);
    checkOutput("arst_kill", ex_kill, 1'b0);
    checkOutput("arst_branch_count", branch_count, 32'h0);
    checkOutput("arst_mispred_count", mispred_count, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_rst_redirect_valid", redirect_valid, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'b001, 32'h1, 32'h2, 32'h800, 32'h880, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
